// File: rtl/mips_defs.sv
// Shared MIPS encodings, writeback-source selector and the W-stage decode helper.
package mips_defs;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

    typedef enum logic [2:0] {
        WSRC_ALU = 3'd0,
        WSRC_MEM = 3'd1,
        WSRC_LUI = 3'd2,
        WSRC_PC8 = 3'd3,
        WSRC_HI  = 3'd4,
        WSRC_LO  = 3'd5
    } wsrc_e;

    typedef enum logic [1:0] {
        LD_W = 2'd0,
        LD_B = 2'd1,
        LD_H = 2'd2
    } ld_e;

    typedef struct packed {
        logic              wr;
        logic [REG_AW-1:0] dst;
        wsrc_e             src;
        ld_e               ld;
    } wb_dec_t;

    // Decode the writeback-relevant fields of one instruction.
    function automatic wb_dec_t wb_decode(input logic [5:0]        op,
                                          input logic [5:0]        funct,
                                          input logic [REG_AW-1:0] rt,
                                          input logic [REG_AW-1:0] rd);
        wb_dec_t d;
        d.wr  = 1'b0;
        d.dst = REG_ZERO;
        d.src = WSRC_ALU;
        d.ld  = LD_W;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU: begin
                        d.wr  = 1'b1;
                        d.dst = rd;
                        d.src = WSRC_ALU;
                    end
                    FN_MFHI: begin
                        d.wr  = 1'b1;
                        d.dst = rd;
                        d.src = WSRC_HI;
                    end
                    FN_MFLO: begin
                        d.wr  = 1'b1;
                        d.dst = rd;
                        d.src = WSRC_LO;
                    end
                    default: d.wr = 1'b0;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                d.wr  = 1'b1;
                d.dst = rt;
                d.src = WSRC_ALU;
            end
            OP_LUI: begin
                d.wr  = 1'b1;
                d.dst = rt;
                d.src = WSRC_LUI;
            end
            OP_LW: begin
                d.wr  = 1'b1;
                d.dst = rt;
                d.src = WSRC_MEM;
                d.ld  = LD_W;
            end
            OP_LB: begin
                d.wr  = 1'b1;
                d.dst = rt;
                d.src = WSRC_MEM;
                d.ld  = LD_B;
            end
            OP_LH: begin
                d.wr  = 1'b1;
                d.dst = rt;
                d.src = WSRC_MEM;
                d.ld  = LD_H;
            end
            OP_JAL: begin
                d.wr  = 1'b1;
                d.dst = REG_RA;
                d.src = WSRC_PC8;
            end
            default: d.wr = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/grf.sv
// 32x32 general register file: $0 hardwired to zero, write-to-read bypass on both ports.
module grf
    import mips_defs::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] a1,
    input  logic [REG_AW-1:0] a2,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2
);

    logic [XLEN-1:0] regs [0:NREG-1];

    // Storage: synchronous clear on reset, $0 never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read port 1 with same-cycle bypass from the writeback port.
    always_comb begin
        rd1 = '0;
        if (a1 == REG_ZERO) begin
            rd1 = '0;
        end else if (we && (a1 == waddr)) begin
            rd1 = wdata;
        end else begin
            rd1 = regs[a1];
        end
    end

    // Read port 2 with same-cycle bypass from the writeback port.
    always_comb begin
        rd2 = '0;
        if (a2 == REG_ZERO) begin
            rd2 = '0;
        end else if (we && (a2 == waddr)) begin
            rd2 = wdata;
        end else begin
            rd2 = regs[a2];
        end
    end

endmodule

// File: rtl/wb_grf.sv
// MIPS writeback stage: decode, load extension, writeback mux, GRF and retire counter.
// Optional macro WB_TRACE_EN adds a simulation-only trace of every register write.
module wb_grf
    import mips_defs::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      MemRdW,
    input  logic [31:0]      ALUOutW,
    input  logic [31:0]      instrW,
    input  logic [31:0]      luiW,
    input  logic [31:0]      PCW,
    input  logic [31:0]      HIW,
    input  logic [31:0]      LOW,
    input  logic [4:0]       A1D,
    input  logic [4:0]       A2D,
    output logic [31:0]      RD1,
    output logic [31:0]      RD2,
    output logic             WEnW,
    output logic [4:0]       WAddrW,
    output logic [31:0]      WDataW,
    output logic [CNT_W-1:0] RetireCnt
);

    wb_dec_t         dec;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] src_data;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    // Instruction decode.
    always_comb begin
        dec = wb_decode(instrW[31:26], instrW[5:0], instrW[20:16], instrW[15:11]);
    end

    // Byte/half lane select and sign extension for loads.
    always_comb begin
        byte_sel  = '0;
        half_sel  = '0;
        load_data = MemRdW;
        case (ALUOutW[1:0])
            2'd0:    byte_sel = MemRdW[7:0];
            2'd1:    byte_sel = MemRdW[15:8];
            2'd2:    byte_sel = MemRdW[23:16];
            default: byte_sel = MemRdW[31:24];
        endcase
        half_sel = ALUOutW[1] ? MemRdW[31:16] : MemRdW[15:0];
        case (dec.ld)
            LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
            default: load_data = MemRdW;
        endcase
    end

    // Writeback source mux.
    always_comb begin
        src_data = '0;
        case (dec.src)
            WSRC_ALU: src_data = ALUOutW;
            WSRC_MEM: src_data = load_data;
            WSRC_LUI: src_data = luiW;
            WSRC_PC8: src_data = PCW + 32'd8;
            WSRC_HI:  src_data = HIW;
            WSRC_LO:  src_data = LOW;
            default:  src_data = '0;
        endcase
    end

    // Writes to $0 are squashed so forwarding never sees them.
    always_comb begin
        WEnW   = 1'b0;
        WAddrW = REG_ZERO;
        WDataW = '0;
        if (dec.wr && (dec.dst != REG_ZERO)) begin
            WEnW   = 1'b1;
            WAddrW = dec.dst;
            WDataW = src_data;
        end
    end

    // Retire counter: every non-nop instruction counts, writing or not.
    always_ff @(posedge clk) begin
        if (reset) begin
            RetireCnt <= '0;
        end else if (instrW != 32'd0) begin
            RetireCnt <= RetireCnt + CNT_W'(1);
        end
    end

    grf u_grf (
        .clk   (clk),
        .reset (reset),
        .we    (WEnW),
        .waddr (WAddrW),
        .wdata (WDataW),
        .a1    (A1D),
        .a2    (A2D),
        .rd1   (RD1),
        .rd2   (RD2)
    );

`ifdef WB_TRACE_EN
    // Simulation-only write trace.
    always @(posedge clk) begin
        if (!reset && WEnW) begin
            $display("@%h: $%d <= %h", PCW, WAddrW, WDataW);
        end
    end
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: hand-computed expectations checked with immediate assertions.
module tb_wb_grf;

    logic        clk;
    logic        reset;
    logic [31:0] MemRdW;
    logic [31:0] ALUOutW;
    logic [31:0] instrW;
    logic [31:0] luiW;
    logic [31:0] PCW;
    logic [31:0] HIW;
    logic [31:0] LOW;
    logic [4:0]  A1D;
    logic [4:0]  A2D;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic        WEnW;
    logic [4:0]  WAddrW;
    logic [31:0] WDataW;
    logic [31:0] RetireCnt;

    int          n_assert;
    int          n_fail;
    logic [31:0] exp_cnt;

    wb_grf #(.CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRdW    (MemRdW),
        .ALUOutW   (ALUOutW),
        .instrW    (instrW),
        .luiW      (luiW),
        .PCW       (PCW),
        .HIW       (HIW),
        .LOW       (LOW),
        .A1D       (A1D),
        .A2D       (A2D),
        .RD1       (RD1),
        .RD2       (RD2),
        .WEnW      (WEnW),
        .WAddrW    (WAddrW),
        .WDataW    (WDataW),
        .RetireCnt (RetireCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock edge; inputs are stable here, so the expected count is updated from them.
    task automatic tick();
        @(posedge clk);
        if (reset) exp_cnt = '0;
        else if (instrW != 32'd0) exp_cnt = exp_cnt + 32'd1;
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_cnt  = '0;
        reset    = 1'b1;
        MemRdW   = '0;
        ALUOutW  = '0;
        instrW   = '0;
        luiW     = '0;
        PCW      = '0;
        HIW      = '0;
        LOW      = '0;
        A1D      = 5'd5;
        A2D      = 5'd6;
        tick();
        tick();
        chk("reset_cnt", RetireCnt, 32'd0);
        chk("reset_rd1", RD1, 32'd0);
        chk("reset_wen", 32'(WEnW), 32'd0);
        reset = 1'b0;

        // lw $8,0($9)
        instrW  = 32'h8D28_0000;
        MemRdW  = 32'h8000_1234;
        ALUOutW = 32'h0000_1000;
        #1;
        chk("lw_wen", 32'(WEnW), 32'd1);
        chk("lw_waddr", 32'(WAddrW), 32'd8);
        chk("lw_wdata", WDataW, 32'h8000_1234);
        tick();
        instrW = 32'h0;
        A1D    = 5'd8;
        #1;
        chk("lw_rd1", RD1, 32'h8000_1234);
        chk("lw_cnt", RetireCnt, exp_cnt);
        chk("lw_cnt_abs", RetireCnt, 32'd1);

        // lb $10 / lh $11 lane selection with MemRdW = 80FF_7F01
        MemRdW  = 32'h80FF_7F01;
        instrW  = 32'h800A_0000;
        ALUOutW = 32'h0000_0002;
        #1;
        chk("lb_b2", WDataW, 32'hFFFF_FFFF);
        chk("lb_addr", 32'(WAddrW), 32'd10);
        ALUOutW = 32'h0000_0001;
        #1;
        chk("lb_b1", WDataW, 32'h0000_007F);
        ALUOutW = 32'h0000_0003;
        #1;
        chk("lb_b3", WDataW, 32'hFFFF_FF80);
        instrW  = 32'h840B_0000;
        ALUOutW = 32'h0000_0002;
        #1;
        chk("lh_h1", WDataW, 32'hFFFF_80FF);
        chk("lh_addr", 32'(WAddrW), 32'd11);
        ALUOutW = 32'h0000_0001;
        #1;
        chk("lh_h0_misalign", WDataW, 32'h0000_7F01);
        instrW  = 32'h8D28_0000;
        ALUOutW = 32'h0000_0003;
        #1;
        chk("lw_misalign", WDataW, 32'h80FF_7F01);
        tick();

        // jal with same-cycle bypass on both ports
        instrW = 32'h0C00_0C04;
        PCW    = 32'h0000_3010;
        A1D    = 5'd31;
        A2D    = 5'd31;
        #1;
        chk("jal_waddr", 32'(WAddrW), 32'd31);
        chk("jal_wdata", WDataW, 32'h0000_3018);
        chk("jal_byp_rd2", RD2, 32'h0000_3018);
        chk("jal_byp_rd1", RD1, 32'h0000_3018);
        tick();

        // addi $0,$0,5 is squashed but retires
        instrW  = 32'h2000_0005;
        ALUOutW = 32'h0000_0005;
        A1D     = 5'd0;
        A2D     = 5'd8;
        #1;
        chk("zero_wen", 32'(WEnW), 32'd0);
        chk("zero_waddr", 32'(WAddrW), 32'd0);
        chk("zero_wdata", WDataW, 32'd0);
        chk("zero_rd1", RD1, 32'd0);
        tick();
        chk("zero_cnt", RetireCnt, exp_cnt);
        chk("zero_cnt_abs", RetireCnt, 32'd4);

        // mfhi $3, then sw/beq/nop: no writes, count advances by 2
        instrW = 32'h0000_1810;
        HIW    = 32'hDEAD_BEEF;
        #1;
        chk("mfhi_wdata", WDataW, 32'hDEAD_BEEF);
        chk("mfhi_waddr", 32'(WAddrW), 32'd3);
        tick();
        instrW = 32'hAC03_0000;
        A1D    = 5'd3;
        #1;
        chk("sw_wen", 32'(WEnW), 32'd0);
        chk("mfhi_rd1", RD1, 32'hDEAD_BEEF);
        tick();
        instrW = 32'h1003_0003;
        #1;
        chk("beq_wen", 32'(WEnW), 32'd0);
        tick();
        instrW = 32'h0;
        #1;
        chk("nop_wen", 32'(WEnW), 32'd0);
        tick();
        chk("store_br_nop_cnt", RetireCnt, 32'd7);

        // mflo $4, sltu $7, mult (no write)
        instrW = 32'h0000_2012;
        LOW    = 32'h1357_9BDF;
        #1;
        chk("mflo_wdata", WDataW, 32'h1357_9BDF);
        instrW  = 32'h0000_382B;
        ALUOutW = 32'h0000_0001;
        #1;
        chk("sltu_waddr", 32'(WAddrW), 32'd7);
        chk("sltu_wdata", WDataW, 32'h0000_0001);
        instrW = 32'h0128_0018;
        #1;
        chk("mult_wen", 32'(WEnW), 32'd0);

        // ori $5, lui $6, then reset clears everything
        instrW  = 32'h3405_0055;
        ALUOutW = 32'h0000_0055;
        tick();
        instrW = 32'h3C06_1234;
        luiW   = 32'h1234_0000;
        tick();
        instrW = 32'h0;
        A1D    = 5'd5;
        A2D    = 5'd6;
        #1;
        chk("ori_rd1", RD1, 32'h0000_0055);
        chk("lui_rd2", RD2, 32'h1234_0000);
        chk("pre_reset_cnt", RetireCnt, exp_cnt);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_rd1", RD1, 32'd0);
        chk("rst_rd2", RD2, 32'd0);
        chk("rst_cnt", RetireCnt, 32'd0);
        A1D = 5'd3;
        A2D = 5'd31;
        #1;
        chk("rst_rd3", RD1, 32'd0);
        chk("rst_rd31", RD2, 32'd0);

        // Write presented during reset is discarded
        reset   = 1'b1;
        instrW  = 32'h3409_0099;
        ALUOutW = 32'h0000_0099;
        tick();
        reset  = 1'b0;
        instrW = 32'h0;
        A1D    = 5'd9;
        #1;
        chk("rst_write_drop", RD1, 32'd0);
        chk("rst_write_cnt", RetireCnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
